// File: rtl/signed_mult_pkg.sv
// Shared definitions for the signed shift-add multiplier: state encoding and default width.
package signed_mult_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/signed_mult_dp.sv
// Multiplier datapath: operand capture, magnitudes, shift-add accumulator and final sign fix.
module signed_mult_dp
  import signed_mult_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned CW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [CW-1:0]   cnt,
  output logic [2*W-1:0]  product
);

  localparam int unsigned PW = 2 * W;

  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  mag_a_q, mag_b_q;
  logic          neg_q;
  logic [PW-1:0] acc_q, product_q;
  logic [W-1:0]  mag_a_c, mag_b_c;
  logic [PW-1:0] addend_c;

  // |-2^(W-1)| wraps back to 2^(W-1), which is exactly right as an unsigned magnitude.
  always_comb begin
    mag_a_c  = a_q[W-1] ? ((~a_q) + W'(1)) : a_q;
    mag_b_c  = b_q[W-1] ? ((~b_q) + W'(1)) : b_q;
    addend_c = PW'(mag_a_q) << cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      if (capture) begin
        a_q <= a;
        b_q <= b;
      end
      if (load) begin
        mag_a_q <= mag_a_c;
        mag_b_q <= mag_b_c;
        neg_q   <= a_q[W-1] ^ b_q[W-1];
        acc_q   <= '0;
      end
      if (step) begin
        if (mag_b_q[0]) acc_q <= acc_q + addend_c;
        mag_b_q <= mag_b_q >> 1;
      end
      if (fix) product_q <= neg_q ? ((~acc_q) + PW'(1)) : acc_q;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/signed_mult_ctrl.sv
// Sequencer for the iterative signed multiplier: FSM, bit counter and busy/done status.
module signed_mult_ctrl
  import signed_mult_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_d, done_d;
  logic          capture_c, load_c, step_c, fix_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Status flags are decoded from the next state so they line up with the registered state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    load_c    = 1'b0;
    step_c    = 1'b0;
    fix_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        load_c  = 1'b1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        step_c = 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = S_FIX;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_FIX: begin
        fix_c   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  signed_mult_dp #(.W(W), .CW(CW)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture_c),
    .load    (load_c),
    .step    (step_c),
    .fix     (fix_c),
    .a       (a),
    .b       (b),
    .cnt     (cnt_q),
    .product (product)
  );

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// Directed scoreboard bench for signed_mult_ctrl (W=8): latency, status flags, results, ignored starts, reset abort.
module tb_signed_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          n_cmp;
  int          n_bad;
  logic [15:0] sb[$];
  logic [15:0] last_product;

  signed_mult_ctrl #(.W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the next posedge (edge 0),
  // so negedge k afterwards lies in cycle k.
  task automatic run_op(input int ta, input int tb_v, input int inject_cyc,
                        input int abort_cyc, input bit start_in_done);
    int  cyc;
    bit  done_seen;
    logic [15:0] exp_p;
    logic [15:0] got;
    string nm;
    nm    = $sformatf("%0d*%0d", ta, tb_v);
    exp_p = 16'(ta * tb_v);
    a     = 8'(ta);
    b     = 8'(tb_v);
    start = 1'b1;
    sb.push_back(exp_p);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    done_seen = 1'b0;
    while (!done_seen && cyc <= 20) begin
      if (cyc == 5) chk({nm, " product held during run"}, 32'(product), 32'(last_product));
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " abort busy"}, 32'(busy), 32'd0);
        chk({nm, " abort done"}, 32'(done), 32'd0);
        chk({nm, " abort product"}, 32'(product), 32'd0);
        void'(sb.pop_front());
        last_product = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          chk({nm, " no done after abort"}, 32'(done), 32'd0);
        end
        return;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({nm, " done cycle"}, 32'(cyc), 32'd11);
        chk({nm, " busy at done"}, 32'(busy), 32'd0);
        got = sb.pop_front();
        chk({nm, " product"}, 32'(product), 32'(got));
        last_product = got;
      end else begin
        chk($sformatf("%s busy c%0d", nm, cyc), 32'(busy), (cyc <= 10) ? 32'd1 : 32'd0);
        if (cyc == inject_cyc) begin
          a     = 8'hFF;
          b     = 8'h81;
          start = 1'b1;
        end else if (cyc == inject_cyc + 1) begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) begin
      chk({nm, " done timeout"}, 32'd0, 32'd1);
      return;
    end
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done one cycle"}, 32'(done), 32'd0);
    chk({nm, " idle after done"}, 32'(busy), 32'd0);
    chk({nm, " product kept"}, 32'(product), 32'(last_product));
    @(negedge clk);
    chk({nm, " stays idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_product = 16'h0000;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    run_op(3, 5, 0, 0, 1'b0);
    chk("3*5 literal", 32'(last_product), 32'h000F);
    run_op(-3, 5, 0, 0, 1'b0);
    chk("-3*5 literal", 32'(last_product), 32'hFFF1);
    run_op(5, -3, 0, 0, 1'b0);
    run_op(-128, -128, 0, 0, 1'b0);
    chk("-128*-128 literal", 32'(last_product), 32'h4000);
    run_op(127, -128, 0, 0, 1'b0);
    chk("127*-128 literal", 32'(last_product), 32'hC080);
    run_op(0, -7, 0, 0, 1'b1);
    run_op(7, 9, 4, 0, 1'b0);
    run_op(-1, 1, 0, 0, 1'b0);
    run_op(100, -50, 0, 5, 1'b0);
    run_op(12, -11, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(255)) - 128;
      rb = int'($urandom_range(255)) - 128;
      run_op(ra, rb, 0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
